// File: rtl/galaxian_setup_pkg.sv
// Shared types and constants for the galaxian download/setup front-end.
// Used by ioctl_setup and setup_hold_timer.
package galaxian_setup_pkg;

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } setup_state_e;

   localparam logic [7:0] IDX_ROM = 8'd0;
   localparam logic [7:0] IDX_MOD = 8'd1;
   localparam logic [7:0] IDX_DIP = 8'd254;

   // Game variant numbers as sent in the index-1 select byte
   localparam int MOD_GALAXIAN  = 0;
   localparam int MOD_MOONQSR   = 1;
   localparam int MOD_MOONCRST  = 2;
   localparam int MOD_UNIWARS   = 3;
   localparam int MOD_SWARM     = 4;
   localparam int MOD_ZIGZAG    = 5;
   localparam int MOD_PISCES    = 6;
   localparam int MOD_SKYBASE   = 7;
   localparam int MOD_KINGBAL   = 8;
   localparam int MOD_BLACKHOLE = 9;
   localparam int MOD_ORBITRON  = 10;
   localparam int MOD_OMEGA     = 11;
   localparam int MOD_WAROFBUG  = 12;
   localparam int MOD_REDUFO    = 13;
   localparam int MOD_AZURIAN   = 14;
   localparam int MOD_DEVILFSH  = 15;
   localparam int MOD_TRIPLEDR  = 16;
   localparam int MOD_LUCKTODAY = 17;

endpackage

// File: rtl/setup_hold_timer.sv
// Down-counter that holds the core in reset for RESET_HOLD cycles.
// 'load' reloads RESET_HOLD-1; 'en' counts down; 'done' flags zero.
module setup_hold_timer #(
   parameter int RESET_HOLD = 256
) (
   input  logic clk_sys,
   input  logic load,
   input  logic en,
   output logic done
);
   localparam int CW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(RESET_HOLD - 1);

   logic [CW-1:0] count_q = RELOAD;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = RELOAD;
      end else if (en && count_q != '0) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk_sys) begin
      count_q <= count_d;
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/ioctl_setup.sv
// Decodes hps_io ioctl traffic into ROM, game-select and DIP streams and
// sequences the core reset. Optional ROM checksum: define IOCTL_ROM_SUM_EN.
module ioctl_setup #(
   parameter int MOD_COUNT  = 18,
   parameter int RESET_HOLD = 256,
   parameter int DIP_BYTES  = 8,
   parameter int ROM_ADDR_W = 16
) (
   input  logic                   clk_sys,
   input  logic                   reset,
   input  logic                   ioctl_download,
   input  logic                   ioctl_wr,
   input  logic [7:0]             ioctl_index,
   input  logic [24:0]            ioctl_addr,
   input  logic [7:0]             ioctl_dout,
   output logic [ROM_ADDR_W-1:0]  dn_addr,
   output logic [7:0]             dn_data,
   output logic                   dn_wr,
   output logic [4:0]             mod_id,
   output logic [MOD_COUNT-1:0]   mod_onehot,
   output logic [8*DIP_BYTES-1:0] dip_sw,
   output logic                   core_reset,
   output logic                   rom_ready,
   output logic [7:0]             rom_sum
);
   import galaxian_setup_pkg::*;

   // Configuration registers power up to defaults and survive user resets
   setup_state_e            state_q = ST_HOLD;
   setup_state_e            state_d;
   logic                    rom_ready_q = 1'b0;
   logic                    rom_ready_d;
   logic [ROM_ADDR_W-1:0]   dn_addr_q = '0;
   logic [ROM_ADDR_W-1:0]   dn_addr_d;
   logic [7:0]              dn_data_q = '0;
   logic [7:0]              dn_data_d;
   logic                    dn_wr_q = 1'b0;
   logic                    dn_wr_d;
   logic [7:0]              mod_raw_q = '0;
   logic [7:0]              mod_raw_d;
   logic [MOD_COUNT-1:0]    mod_onehot_q = MOD_COUNT'(1);
   logic [MOD_COUNT-1:0]    mod_onehot_d;
   logic [8*DIP_BYTES-1:0]  dip_sw_q = '1;
   logic [8*DIP_BYTES-1:0]  dip_sw_d;

   logic rom_hit, mod_hit, dip_hit, load_req;
   logic timer_load, timer_en, timer_done;

   assign rom_hit  = ioctl_wr && (ioctl_index == IDX_ROM) &&
                     ((ioctl_addr >> ROM_ADDR_W) == 25'd0);
   assign mod_hit  = ioctl_wr && (ioctl_index == IDX_MOD);
   assign dip_hit  = ioctl_wr && (ioctl_index == IDX_DIP) &&
                     (ioctl_addr[24:3] == 22'd0) &&
                     ({1'b0, ioctl_addr[2:0]} < 4'(DIP_BYTES));
   assign load_req = ioctl_download && (ioctl_index == IDX_ROM);

   assign mod_id = (mod_raw_q < 8'(MOD_COUNT)) ? mod_raw_q[4:0] : 5'd0;

   always_comb begin
      dn_wr_d   = rom_hit;
      dn_addr_d = dn_addr_q;
      dn_data_d = dn_data_q;
      // A qualifying write wins over reset so no ROM byte is lost
      if (rom_hit) begin
         dn_addr_d = ioctl_addr[ROM_ADDR_W-1:0];
         dn_data_d = ioctl_dout;
      end else if (reset) begin
         dn_addr_d = '0;
         dn_data_d = '0;
      end
      mod_raw_d    = mod_hit ? ioctl_dout : mod_raw_q;
      mod_onehot_d = MOD_COUNT'(1) << mod_id;
      dip_sw_d     = dip_sw_q;
      if (dip_hit) begin
         dip_sw_d[8*ioctl_addr[2:0] +: 8] = ioctl_dout;
      end
   end

   always_comb begin
      state_d     = state_q;
      rom_ready_d = rom_ready_q;
      if (load_req) begin
         state_d = ST_LOAD;
      end else begin
         case (state_q)
            ST_LOAD: if (!ioctl_download) state_d = ST_HOLD;
            ST_HOLD: if (timer_done) begin
               state_d     = ST_RUN;
               rom_ready_d = 1'b1;
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_HOLD;
         endcase
      end
      if (state_d == ST_LOAD) rom_ready_d = 1'b0;
   end

   assign timer_load = reset || (state_q != ST_HOLD);
   assign timer_en   = (state_q == ST_HOLD);

   setup_hold_timer #(
      .RESET_HOLD (RESET_HOLD)
   ) u_hold_timer (
      .clk_sys (clk_sys),
      .load    (timer_load),
      .en      (timer_en),
      .done    (timer_done)
   );

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= ST_HOLD;
      end else begin
         state_q     <= state_d;
         rom_ready_q <= rom_ready_d;
      end
      dn_wr_q      <= dn_wr_d;
      dn_addr_q    <= dn_addr_d;
      dn_data_q    <= dn_data_d;
      mod_raw_q    <= mod_raw_d;
      mod_onehot_q <= mod_onehot_d;
      dip_sw_q     <= dip_sw_d;
   end

   assign dn_wr      = dn_wr_q;
   assign dn_addr    = dn_addr_q;
   assign dn_data    = dn_data_q;
   assign mod_onehot = mod_onehot_q;
   assign dip_sw     = dip_sw_q;
   assign rom_ready  = rom_ready_q;
   assign core_reset = reset | (state_q != ST_RUN);

`ifdef IOCTL_ROM_SUM_EN
   logic [7:0] rom_sum_q = '0;
   logic [7:0] rom_sum_d;
   logic       sum_en_q = 1'b0;
   logic       sum_en_d;
   logic       load_entry;

   // Only bytes written while in LOAD count, including one coincident with download falling
   assign load_entry = !reset && (state_d == ST_LOAD) && (state_q != ST_LOAD);
   assign sum_en_d   = rom_hit && (state_q == ST_LOAD);

   always_comb begin
      rom_sum_d = rom_sum_q;
      if (load_entry) begin
         rom_sum_d = 8'h00;
      end else if (sum_en_q) begin
         rom_sum_d = rom_sum_q + dn_data_q;
      end
   end

   always_ff @(posedge clk_sys) begin
      sum_en_q  <= sum_en_d;
      rom_sum_q <= rom_sum_d;
   end

   assign rom_sum = rom_sum_q;
`else
   assign rom_sum = 8'h00;
`endif

endmodule
